// File: rtl/ysyx_24100006_pipe_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: load-use stall, GPR forwarding, redirect and fence.i sequencing.
// Optional macro YSYX_24100006_PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module ysyx_24100006_pipe_ctrl #(
    parameter int ADDR_W = 4,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic              ex_wen_i,
    input  logic              ex_is_load_i,
    input  logic              ex_redirect_i,
    input  logic [PC_W-1:0]   ex_target_i,
    input  logic              ex_fence_i_i,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic              mem_valid_i,
    input  logic              mem_wen_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic              wb_valid_i,
    input  logic              wb_wen_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic              lsu_idle_i,
    input  logic              ifu_ready_i,
    input  logic              icache_flush_ack_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [1:0]        fwd_rs1_o,
    output logic [1:0]        fwd_rs2_o,
    output logic              redirect_valid_o,
    output logic [PC_W-1:0]   redirect_pc_o,
`ifdef YSYX_24100006_PIPE_CTRL_PERF_EN
    output logic              icache_flush_req_o,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
`else
    output logic              icache_flush_req_o
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REDIR  = 2'd1,
        FDRAIN = 2'd2,
        FFLUSH = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   target_reg, target_next;
    logic              req_reg, req_next;

    logic              stall_raw, flush_raw, redir_raw;
    logic [PC_W-1:0]   redir_pc_raw;

    logic [1:0][ADDR_W-1:0] id_rs;
    logic [1:0]             id_use;
    logic [1:0][1:0]        fwd_sel;
    logic [1:0]             rs_hazard;
    logic                   load_use;

    assign id_rs  = {id_rs2_i, id_rs1_i};
    assign id_use = {id_use_rs2_i, id_use_rs1_i};

    // Youngest producer wins; x0 is hard-wired so it never forwards.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign fwd_sel[gi] =
                (id_rs[gi] == '0)                                     ? 2'd0 :
                (ex_valid_i  && ex_wen_i  && (ex_rd_i  == id_rs[gi])) ? 2'd1 :
                (mem_valid_i && mem_wen_i && (mem_rd_i == id_rs[gi])) ? 2'd2 :
                (wb_valid_i  && wb_wen_i  && (wb_rd_i  == id_rs[gi])) ? 2'd3 :
                                                                        2'd0;
            assign rs_hazard[gi] = id_use[gi] && (ex_rd_i == id_rs[gi]);
        end
    endgenerate

    assign load_use = id_valid_i && ex_valid_i && ex_is_load_i && ex_wen_i &&
                      (ex_rd_i != '0) && (|rs_hazard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            target_reg <= '0;
            req_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            req_reg    <= req_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        req_next     = req_reg;
        stall_raw    = 1'b0;
        flush_raw    = 1'b0;
        redir_raw    = 1'b0;
        redir_pc_raw = '0;
        case (state_reg)
            RUN: begin
                if (ex_valid_i && ex_fence_i_i) begin
                    flush_raw   = 1'b1;
                    target_next = ex_pc_i + PC_W'(4);
                    state_next  = FDRAIN;
                end else if (ex_valid_i && ex_redirect_i) begin
                    flush_raw    = 1'b1;
                    redir_raw    = 1'b1;
                    redir_pc_raw = ex_target_i;
                    if (!ifu_ready_i) begin
                        target_next = ex_target_i;
                        state_next  = REDIR;
                    end
                end else begin
                    stall_raw = load_use;
                end
            end
            REDIR: begin
                flush_raw    = 1'b1;
                redir_raw    = 1'b1;
                redir_pc_raw = target_reg;
                if (ifu_ready_i) state_next = RUN;
            end
            FDRAIN: begin
                stall_raw = 1'b1;
                flush_raw = 1'b1;
                // Older instructions must retire before the icache may be invalidated.
                if (!mem_valid_i && !wb_valid_i && lsu_idle_i) begin
                    req_next   = 1'b1;
                    state_next = FFLUSH;
                end
            end
            FFLUSH: begin
                stall_raw = 1'b1;
                flush_raw = 1'b1;
                if (icache_flush_ack_i) begin
                    req_next   = 1'b0;
                    state_next = REDIR;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign stall_o            = !reset && stall_raw;
    assign flush_o            = !reset && flush_raw;
    assign redirect_valid_o   = !reset && redir_raw;
    assign redirect_pc_o      = reset ? '0 : redir_pc_raw;
    assign fwd_rs1_o          = reset ? 2'd0 : fwd_sel[0];
    assign fwd_rs2_o          = reset ? 2'd0 : fwd_sel[1];
    assign icache_flush_req_o = !reset && req_reg;

`ifdef YSYX_24100006_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_reg, perf_flush_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (stall_o) perf_stall_reg <= perf_stall_reg + 32'd1;
            if (flush_o && (state_reg == RUN)) perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_reg;
    assign perf_flush_cnt_o = perf_flush_reg;
`endif

endmodule

// File: tb/tb_ysyx_24100006_pipe_ctrl.sv
// Self-checking bench for ysyx_24100006_pipe_ctrl: table vectors plus redirect/fence/reset sequences.
module tb_ysyx_24100006_pipe_ctrl;

    typedef struct packed {
        logic        rst;
        logic        id_valid;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        use1;
        logic        use2;
        logic        ex_valid;
        logic [3:0]  ex_rd;
        logic        ex_wen;
        logic        ex_load;
        logic        ex_redir;
        logic [31:0] ex_target;
        logic        ex_fence;
        logic [31:0] ex_pc;
        logic        mem_valid;
        logic        mem_wen;
        logic [3:0]  mem_rd;
        logic        wb_valid;
        logic        wb_wen;
        logic [3:0]  wb_rd;
        logic        lsu_idle;
        logic        ifu_ready;
        logic        ack;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string name;
    } vec_t;

    typedef struct {
        out_t  o;
        string name;
    } exp_t;

    logic        clk;
    in_t         cur;
    out_t        act;
    exp_t        sb_q[$];
    exp_t        e_chk;
    vec_t        tbl[$];
    int          total = 0;
    int          bad = 0;

    logic        stall_o, flush_o, redirect_valid_o, icache_flush_req_o;
    logic [1:0]  fwd_rs1_o, fwd_rs2_o;
    logic [31:0] redirect_pc_o;
`ifdef YSYX_24100006_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    ysyx_24100006_pipe_ctrl #(.ADDR_W(4), .PC_W(32)) dut (
        .clk                (clk),
        .reset              (cur.rst),
        .id_valid_i         (cur.id_valid),
        .id_rs1_i           (cur.rs1),
        .id_rs2_i           (cur.rs2),
        .id_use_rs1_i       (cur.use1),
        .id_use_rs2_i       (cur.use2),
        .ex_valid_i         (cur.ex_valid),
        .ex_rd_i            (cur.ex_rd),
        .ex_wen_i           (cur.ex_wen),
        .ex_is_load_i       (cur.ex_load),
        .ex_redirect_i      (cur.ex_redir),
        .ex_target_i        (cur.ex_target),
        .ex_fence_i_i       (cur.ex_fence),
        .ex_pc_i            (cur.ex_pc),
        .mem_valid_i        (cur.mem_valid),
        .mem_wen_i          (cur.mem_wen),
        .mem_rd_i           (cur.mem_rd),
        .wb_valid_i         (cur.wb_valid),
        .wb_wen_i           (cur.wb_wen),
        .wb_rd_i            (cur.wb_rd),
        .lsu_idle_i         (cur.lsu_idle),
        .ifu_ready_i        (cur.ifu_ready),
        .icache_flush_ack_i (cur.ack),
        .stall_o            (stall_o),
        .flush_o            (flush_o),
        .fwd_rs1_o          (fwd_rs1_o),
        .fwd_rs2_o          (fwd_rs2_o),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
`ifdef YSYX_24100006_PIPE_CTRL_PERF_EN
        .icache_flush_req_o (icache_flush_req_o),
        .perf_stall_cnt_o   (perf_stall_cnt_o),
        .perf_flush_cnt_o   (perf_flush_cnt_o)
`else
        .icache_flush_req_o (icache_flush_req_o)
`endif
    );

    assign act = {stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, redirect_valid_o, redirect_pc_o, icache_flush_req_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t idle_in();
        in_t v;
        v = '0;
        v.lsu_idle  = 1'b1;
        v.ifu_ready = 1'b1;
        return v;
    endfunction

    // Load x5 in EXE while ID reads x5 through rs1.
    function automatic in_t lu_in();
        in_t v;
        v = idle_in();
        v.id_valid = 1'b1;
        v.rs1      = 4'd5;
        v.use1     = 1'b1;
        v.ex_valid = 1'b1;
        v.ex_rd    = 4'd5;
        v.ex_wen   = 1'b1;
        v.ex_load  = 1'b1;
        return v;
    endfunction

    function automatic out_t mk_out(input logic s, input logic f, input logic [1:0] a, input logic [1:0] b,
                                    input logic rv, input logic [31:0] pc, input logic rq);
        out_t o;
        o.stall = s; o.flush = f; o.f1 = a; o.f2 = b; o.rv = rv; o.rpc = pc; o.req = rq;
        return o;
    endfunction

    function automatic void add(input in_t v, input out_t o, input string n);
        vec_t t;
        t.i = v; t.o = o; t.name = n;
        tbl.push_back(t);
    endfunction

    // One cycle of stimulus; the expected output for that cycle goes to the scoreboard.
    task automatic step(input in_t v, input out_t o, input string n);
        exp_t x;
        @(posedge clk);
        #1;
        cur = v;
        x.o = o; x.name = n;
        sb_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            e_chk = sb_q.pop_front();
            total++;
            if (act !== e_chk.o) begin
                bad++;
                $display("FAIL %s: got stall=%0b flush=%0b f1=%0d f2=%0d rv=%0b pc=%h req=%0b want stall=%0b flush=%0b f1=%0d f2=%0d rv=%0b pc=%h req=%0b",
                         e_chk.name, act.stall, act.flush, act.f1, act.f2, act.rv, act.rpc, act.req,
                         e_chk.o.stall, e_chk.o.flush, e_chk.o.f1, e_chk.o.f2, e_chk.o.rv, e_chk.o.rpc, e_chk.o.req);
            end else begin
                $display("ok   %s: stall=%0b flush=%0b f1=%0d f2=%0d rv=%0b pc=%h req=%0b",
                         e_chk.name, act.stall, act.flush, act.f1, act.f2, act.rv, act.rpc, act.req);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;
        cur = idle_in();
        cur.rst = 1'b1;

        // Table of single-cycle RUN vectors; none of them leaves RUN.
        add(idle_in(), mk_out(0,0,0,0,0,0,0), "idle");
        add(lu_in(), mk_out(1,0,1,0,0,0,0), "load_use_rs1");
        v = lu_in(); v.rs1 = 4'd3; v.use1 = 1'b1; v.rs2 = 4'd5; v.use2 = 1'b0;
        add(v, mk_out(0,0,0,1,0,0,0), "rs2_match_unused");
        v = lu_in(); v.rs2 = 4'd5; v.use2 = 1'b1; v.rs1 = 4'd0; v.use1 = 1'b1;
        add(v, mk_out(1,0,0,1,0,0,0), "load_use_rs2");
        v = lu_in(); v.rs1 = 4'd0; v.ex_rd = 4'd0;
        add(v, mk_out(0,0,0,0,0,0,0), "load_rd_x0");
        v = lu_in(); v.id_valid = 1'b0;
        add(v, mk_out(0,0,1,0,0,0,0), "load_id_invalid");
        v = lu_in(); v.ex_load = 1'b0;
        add(v, mk_out(0,0,1,0,0,0,0), "alu_fwd_ex");
        v = idle_in(); v.rs2 = 4'd7; v.mem_valid = 1'b1; v.mem_wen = 1'b1; v.mem_rd = 4'd7;
        v.wb_valid = 1'b1; v.wb_wen = 1'b1; v.wb_rd = 4'd7;
        add(v, mk_out(0,0,0,2,0,0,0), "fwd_mem_over_wb");
        v = idle_in(); v.rs2 = 4'd7; v.wb_valid = 1'b1; v.wb_wen = 1'b1; v.wb_rd = 4'd7;
        add(v, mk_out(0,0,0,3,0,0,0), "fwd_wb");
        v = idle_in(); v.ex_valid = 1'b1; v.ex_wen = 1'b1; v.mem_valid = 1'b1; v.mem_wen = 1'b1;
        v.wb_valid = 1'b1; v.wb_wen = 1'b1;
        add(v, mk_out(0,0,0,0,0,0,0), "fwd_x0_all_match");
        v = idle_in(); v.rs1 = 4'd9; v.ex_valid = 1'b1; v.ex_rd = 4'd9; v.mem_valid = 1'b1; v.mem_wen = 1'b1; v.mem_rd = 4'd9;
        add(v, mk_out(0,0,2,0,0,0,0), "fwd_ex_no_wen");
        v = idle_in(); v.rs1 = 4'd9; v.mem_wen = 1'b1; v.mem_rd = 4'd9; v.wb_valid = 1'b1; v.wb_wen = 1'b1; v.wb_rd = 4'd9;
        add(v, mk_out(0,0,3,0,0,0,0), "fwd_mem_invalid");
        v = lu_in(); v.ex_redir = 1'b1; v.ex_target = 32'h8000_0100;
        add(v, mk_out(0,1,1,0,1,32'h8000_0100,0), "redirect_ready");
        add(idle_in(), mk_out(0,0,0,0,0,0,0), "after_redirect_run");
        v = idle_in(); v.ex_redir = 1'b1; v.ex_target = 32'h8000_0100;
        add(v, mk_out(0,0,0,0,0,0,0), "redirect_ex_invalid");

        // Reset state, with inputs that would otherwise stall, forward and redirect.
        v = lu_in(); v.rst = 1'b1; v.ex_redir = 1'b1; v.ex_target = 32'h8000_0100;
        step(v, mk_out(0,0,0,0,0,0,0), "reset_outputs");

        foreach (tbl[k]) step(tbl[k].i, tbl[k].o, tbl[k].name);

        // Redirect while IFU is busy for three cycles.
        v = idle_in(); v.ex_valid = 1'b1; v.ex_redir = 1'b1; v.ex_target = 32'h8000_0100; v.ifu_ready = 1'b0;
        step(v, mk_out(0,1,0,0,1,32'h8000_0100,0), "redir_busy_c0");
        v = idle_in(); v.ifu_ready = 1'b0; v.ex_target = 32'h0000_1234;
        step(v, mk_out(0,1,0,0,1,32'h8000_0100,0), "redir_hold_c1");
        v = lu_in(); v.ifu_ready = 1'b0;
        step(v, mk_out(0,1,1,0,1,32'h8000_0100,0), "redir_hold_c2_nostall");
        step(idle_in(), mk_out(0,1,0,0,1,32'h8000_0100,0), "redir_hold_c3_ready");
        step(idle_in(), mk_out(0,0,0,0,0,0,0), "redir_back_run");

        // fence.i with drain, icache flush handshake and refetch; fence wins over redirect.
        v = idle_in(); v.ex_valid = 1'b1; v.ex_fence = 1'b1; v.ex_pc = 32'h8000_0200;
        v.ex_redir = 1'b1; v.ex_target = 32'hdead_0000;
        step(v, mk_out(0,1,0,0,0,0,0), "fence_enter");
        v = idle_in(); v.mem_valid = 1'b1; v.mem_wen = 1'b1; v.mem_rd = 4'd7; v.rs2 = 4'd7;
        step(v, mk_out(1,1,0,2,0,0,0), "fdrain_mem1");
        v = idle_in(); v.mem_valid = 1'b1;
        step(v, mk_out(1,1,0,0,0,0,0), "fdrain_mem2");
        v = idle_in(); v.lsu_idle = 1'b0;
        step(v, mk_out(1,1,0,0,0,0,0), "fdrain_lsu_busy");
        step(idle_in(), mk_out(1,1,0,0,0,0,0), "fdrain_done");
        for (int k = 0; k < 3; k++) step(idle_in(), mk_out(1,1,0,0,0,0,1), $sformatf("fflush_req%0d", k));
        v = idle_in(); v.ack = 1'b1;
        step(v, mk_out(1,1,0,0,0,0,1), "fflush_ack");
        v = idle_in(); v.ifu_ready = 1'b0;
        step(v, mk_out(0,1,0,0,1,32'h8000_0204,0), "fence_refetch_busy");
        step(idle_in(), mk_out(0,1,0,0,1,32'h8000_0204,0), "fence_refetch");
        step(idle_in(), mk_out(0,0,0,0,0,0,0), "fence_back_run");

        // Refetch address wraps at 2^32.
        v = idle_in(); v.ex_valid = 1'b1; v.ex_fence = 1'b1; v.ex_pc = 32'hffff_fffc;
        step(v, mk_out(0,1,0,0,0,0,0), "wrap_fence");
        step(idle_in(), mk_out(1,1,0,0,0,0,0), "wrap_drain");
        v = idle_in(); v.ack = 1'b1;
        step(v, mk_out(1,1,0,0,0,0,1), "wrap_ack");
        step(idle_in(), mk_out(0,1,0,0,1,32'h0000_0000,0), "wrap_refetch");
        step(idle_in(), mk_out(0,0,0,0,0,0,0), "wrap_back_run");

        // Reset while the icache flush is pending.
        v = idle_in(); v.ex_valid = 1'b1; v.ex_fence = 1'b1; v.ex_pc = 32'h8000_0300;
        step(v, mk_out(0,1,0,0,0,0,0), "rst_seq_fence");
        step(idle_in(), mk_out(1,1,0,0,0,0,0), "rst_seq_drain");
        step(idle_in(), mk_out(1,1,0,0,0,0,1), "rst_seq_fflush");
        v = lu_in(); v.rst = 1'b1;
        step(v, mk_out(0,0,0,0,0,0,0), "rst_in_fflush");
        step(v, mk_out(0,0,0,0,0,0,0), "rst_held");
        step(lu_in(), mk_out(1,0,1,0,0,0,0), "rst_release_run");
        step(idle_in(), mk_out(0,0,0,0,0,0,0), "rst_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
